// File: rtl/module_name_pkg.sv
`default_nettype none
// ============================================================================
// Module   : module_name_pkg
// Brief    : Shared defaults, sample type and window-size helper for the
//            moving-average filter.
// Revision : 1.0 - initial release
// ============================================================================
package module_name_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    typedef logic [DEF_WIDTH-1:0] sample_t;

    // Ceiling log2 that stays well-defined for depth <= 1 (returns 0).
    function automatic int log2d(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : module_name_pkg
`default_nettype wire

// File: rtl/module_name_if.sv
`default_nettype none
// ============================================================================
// Module   : module_name_if
// Brief    : Sample stream in / averaged stream out. No handshake: one sample
//            per clock in each direction.
// Revision : 1.0 - initial release
// ============================================================================
interface module_name_if
    import module_name_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;

    // Producer/consumer side.
    modport master (output data_i, input data_o);
    // Filter side.
    modport slave  (input data_i, output data_o);

endinterface : module_name_if
`default_nettype wire

// File: rtl/module_name_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : module_name_delay_line
// Brief    : DEPTH x WIDTH shift register with asynchronous clear; exposes the
//            newest and oldest taps.
// Revision : 1.0 - initial release
// ============================================================================
module module_name_delay_line
    import module_name_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_newest,
    output logic      [WIDTH-1:0] o_oldest
);

    logic [WIDTH-1:0] r_hist [DEPTH];

    // Shift one place per clock; entry 0 takes the incoming sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_hist[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

    assign o_newest = r_hist[0];
    assign o_oldest = r_hist[DEPTH-1];

endmodule : module_name_delay_line
`default_nettype wire

// File: rtl/module_name_block.sv
`default_nettype none
// ============================================================================
// Module   : module_name_block
// Brief    : Streaming moving-average filter. Keeps an exact running sum of
//            the last DEPTH samples and registers floor(sum / DEPTH).
// Revision : 1.0 - initial release
// ============================================================================
module module_name_block
    import module_name_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    module_name_if.slave bus
);

    localparam int c_log2d = log2d(DEPTH);
    // Sum can reach DEPTH*(2^WIDTH-1), which fits exactly in WIDTH+log2(DEPTH).
    localparam int c_sumw  = WIDTH + c_log2d;

    // Window length must be a power of two in 2..64; sample width non-zero.
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("module_name_block: DEPTH must be a power of two in 2..64");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("module_name_block: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0]  w_oldest;
    logic [WIDTH-1:0]  w_newest_unused;
    logic [c_sumw-1:0] w_sum_next;
    logic [c_sumw-1:0] r_sum;
    logic [WIDTH-1:0]  r_out;

    module_name_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_delay_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (bus.data_i),
        .o_newest (w_newest_unused),
        .o_oldest (w_oldest)
    );

    // Add the entering sample, drop the one leaving the window. The oldest
    // entry is zero until the window has filled, so the divisor is always DEPTH.
    assign w_sum_next = r_sum + c_sumw'(bus.data_i) - c_sumw'(w_oldest);

    // Running sum and truncated average; both clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_out <= '0;
        end else begin
            r_sum <= w_sum_next;
            r_out <= w_sum_next[c_sumw-1:c_log2d];
        end
    end

    assign bus.data_o = r_out;

endmodule : module_name_block
`default_nettype wire

// File: tb/tb_module_name_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_module_name_block
// Brief    : Scoreboard bench for the moving-average filter: directed cases
//            with literal expectations plus a randomized run against a
//            window-sum reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_module_name_block;
    import module_name_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] exp;
        string            tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    sample_t win[$];

    module_name_if #(.WIDTH(WIDTH)) bus ();

    module_name_block #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: average of the last DEPTH samples, missing ones as zero.
    function automatic logic [WIDTH-1:0] model_push(input sample_t s);
        longint unsigned total;
        win.push_front(s);
        if (win.size() > DEPTH) void'(win.pop_back());
        total = 0;
        foreach (win[i]) total += longint'(win[i]);
        return WIDTH'(total / DEPTH);
    endfunction

    // Called at a negedge: present a sample, queue its expected average,
    // advance to the next negedge.
    task automatic drive(input sample_t s, input logic [WIDTH-1:0] exp,
                         input bit use_model, input string tag);
        logic [WIDTH-1:0] m;
        bus.data_i = s;
        m = model_push(s);
        exp_q.push_back('{exp: use_model ? m : exp, tag: tag});
        @(negedge clk);
    endtask

    // Called at a negedge: hold reset with all-ones input, release at a negedge.
    task automatic apply_reset();
        rst_n = 1'b0;
        bus.data_i = '1;
        win.delete();
        repeat (3) begin
            @(posedge clk);
            #1 check("reset_hold", bus.data_o, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every output after a sampled edge is compared to the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, bus.data_o, e.exp);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] step_exp [5];
        logic [WIDTH-1:0] imp_in   [6];
        logic [WIDTH-1:0] imp_exp  [6];
        logic [WIDTH-1:0] fs_exp   [6];
        sample_t          s;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.data_i = '1;
        @(negedge clk);

        // Reset with all-ones input held.
        apply_reset();

        // Step of 4s.
        step_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd4};
        for (int i = 0; i < 5; i++) drive(32'd4, step_exp[i], 1'b0, $sformatf("step[%0d]", i));

        // Impulse.
        apply_reset();
        imp_in  = '{32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        imp_exp = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) drive(imp_in[i], imp_exp[i], 1'b0, $sformatf("impulse[%0d]", i));

        // Truncation: floor, not round.
        apply_reset();
        for (int i = 0; i < 5; i++) drive(32'd1, (i == 3 || i == 4) ? 32'd1 : 32'd0, 1'b0,
                                          $sformatf("trunc[%0d]", i));
        drive(32'd3, 32'd1, 1'b0, "trunc_sum6");
        drive(32'd3, 32'd2, 1'b0, "trunc_sum8");

        // Full scale, no wrap, then a zero.
        apply_reset();
        fs_exp = '{32'h3FFF_FFFF, 32'h7FFF_FFFF, 32'hBFFF_FFFF,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) drive(32'hFFFF_FFFF, fs_exp[i], 1'b0, $sformatf("fullscale[%0d]", i));
        drive(32'd0, 32'hBFFF_FFFF, 1'b0, "fullscale_drop");

        // Mid-stream asynchronous reset, then restart from an empty window.
        apply_reset();
        for (int i = 0; i < 3; i++) drive(32'd4, step_exp[i], 1'b0, $sformatf("pre_rst[%0d]", i));
        #2 rst_n = 1'b0;
        #1 check("async_reset", bus.data_o, '0);
        win.delete();
        bus.data_i = '1;
        @(posedge clk);
        #1 check("async_hold", bus.data_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(32'd4, step_exp[i], 1'b0, $sformatf("restart[%0d]", i));

        // Randomized stream against the reference model, corners weighted in.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       s = '0;
                1:       s = '1;
                default: s = $urandom;
            endcase
            drive(s, '0, 1'b1, $sformatf("rand[%0d]", i));
        end

        // Drain: every queued expectation must have been consumed.
        repeat (DEPTH + 2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_module_name_block
`default_nettype wire
